// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single memory/IO bus between master 0 (processor) and master 1
// (loader / DMA). Every transaction runs IDLE/ACK -> ACCESS -> ACK. The bus
// address, write data and write strobe are registered from the winning master
// at the arbitration edge. Arbitration happens on every edge taken in IDLE or
// ACK, so a master that holds req through its ack gets back-to-back service.
//
// Compile-time option:
//   ARB_FAIR_EN  defined   -> burst-limited round-robin (MAX_BURST grants max)
//                undefined -> fixed priority, m0 wins every tie
//
// Parameters:
//   AW         address width
//   DW         data width
//   MAX_BURST  max consecutive grants to one master while the other waits (>= 1)
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   m0_* / m1_*  (in)          req, we, addr, wdata of each master
//   m0_gnt / m1_gnt  (out)     high in that master's ACCESS cycle
//   m0_ack / m1_ack  (out)     one-cycle pulse in that master's ACK cycle
//   m0_rdata / m1_rdata (out)  bus_rdata during the matching ack, else 0
//   bus_addr, bus_wdata, bus_we (out)  registered bus drive
//   bus_rdata (in)             synchronous read data, valid in the ACK cycle
//   owner (out)                last granted master
//   busy (out)                 state is not IDLE
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_we,
  input  logic [DW-1:0] bus_rdata,
  output logic          owner,
  output logic          busy
);

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("mem_bus_arbiter: MAX_BURST must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_owner;
  logic [AW-1:0] r_bus_addr;
  logic [DW-1:0] r_bus_wdata;
  logic          r_bus_we;
  logic          r_m0_gnt;
  logic          r_m1_gnt;
  logic          r_m0_ack;
  logic          r_m1_ack;
  logic          r_busy;

  logic          w_any_req;
  logic          w_arb;
  logic          w_winner;

  assign w_any_req = m0_req | m1_req;
  // Every state except ACCESS is an arbitration point.
  assign w_arb     = (r_state != S_ACCESS);

`ifdef ARB_FAIR_EN
  localparam int            CW      = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  logic [CW-1:0] r_cnt;

  // Burst counter: restarts at 1 on a change of owner, saturates otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= MAX_CNT;
    end else if (w_arb && w_any_req) begin
      if (w_winner != r_owner) begin
        r_cnt <= CW'(1);
      end else if (r_cnt < MAX_CNT) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
`endif

  // NOTE: w_winner gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    w_winner = 1'b0;
    if (m0_req && m1_req) begin
`ifdef ARB_FAIR_EN
      // Owner keeps the bus until its burst quota is used up.
      w_winner = (r_cnt < MAX_CNT) ? r_owner : ~r_owner;
`else
      w_winner = 1'b0;
`endif
    end else begin
      w_winner = m1_req;
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b1;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_we    <= 1'b0;
      r_m0_gnt    <= 1'b0;
      r_m1_gnt    <= 1'b0;
      r_m0_ack    <= 1'b0;
      r_m1_ack    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_ACCESS: begin
          r_state  <= S_ACK;
          r_bus_we <= 1'b0;
          r_m0_gnt <= 1'b0;
          r_m1_gnt <= 1'b0;
          r_m0_ack <= ~r_owner;
          r_m1_ack <= r_owner;
          r_busy   <= 1'b1;
        end
        default: begin  // S_IDLE, S_ACK (and the unused encoding)
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          if (w_any_req) begin
            r_state     <= S_ACCESS;
            r_bus_addr  <= w_winner ? m1_addr  : m0_addr;
            r_bus_wdata <= w_winner ? m1_wdata : m0_wdata;
            r_bus_we    <= w_winner ? m1_we    : m0_we;
            r_owner     <= w_winner;
            r_m0_gnt    <= ~w_winner;
            r_m1_gnt    <= w_winner;
            r_busy      <= 1'b1;
          end else begin
            // Address and data hold; only the strobe is cleared.
            r_state  <= S_IDLE;
            r_bus_we <= 1'b0;
            r_m0_gnt <= 1'b0;
            r_m1_gnt <= 1'b0;
            r_busy   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign m0_gnt    = r_m0_gnt;
  assign m1_gnt    = r_m1_gnt;
  assign m0_ack    = r_m0_ack;
  assign m1_ack    = r_m1_ack;
  assign m0_rdata  = r_m0_ack ? bus_rdata : '0;
  assign m1_rdata  = r_m1_ack ? bus_rdata : '0;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_we    = r_bus_we;
  assign owner     = r_owner;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Self-checking bench for mem_bus_arbiter (MAX_BURST = 2). A table of
// single-cycle vectors covers single write, single read and a request dropped
// before its ack; hand-written sequences cover the reset-time tie, continuous
// contention and a reset pulse in the middle of a write. Expectations for the
// contention sequence follow ARB_FAIR_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic          bus_we, owner, busy;

  int n_tests = 0;
  int n_fail  = 0;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m0_gnt   (m0_gnt),
    .m1_gnt   (m1_gnt),
    .m0_ack   (m0_ack),
    .m1_ack   (m1_ack),
    .m0_rdata (m0_rdata),
    .m1_rdata (m1_rdata),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_we   (bus_we),
    .bus_rdata(bus_rdata),
    .owner    (owner),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m0_req;
    logic        m0_we;
    logic [15:0] m0_addr;
    logic [15:0] m0_wdata;
    logic        m1_req;
    logic        m1_we;
    logic [15:0] m1_addr;
    logic [15:0] m1_wdata;
    logic [15:0] rdata;
    logic        e_m0_gnt;
    logic        e_m1_gnt;
    logic        e_m0_ack;
    logic        e_m1_ack;
    logic        e_bus_we;
    logic        e_busy;
    logic        e_owner;
    logic [15:0] e_m0_rdata;
    logic [15:0] e_m1_rdata;
    logic [15:0] e_bus_addr;
    logic [15:0] e_bus_wdata;
    string       name;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    bus_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_order;

    // Inputs applied before an edge; expected outputs sampled 1 ns after it.
    vecs[0] = '{1,1,16'h0010,16'h1234, 0,0,16'h0000,16'h0000, 16'h0000,
                1,0,0,0,1,1,0, 16'h0000,16'h0000,16'h0010,16'h1234, "wr_access"};
    vecs[1] = '{1,1,16'h0010,16'h1234, 0,0,16'h0000,16'h0000, 16'h5555,
                0,0,1,0,0,1,0, 16'h5555,16'h0000,16'h0010,16'h1234, "wr_ack"};
    vecs[2] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h5555,
                0,0,0,0,0,0,0, 16'h0000,16'h0000,16'h0010,16'h1234, "wr_idle"};
    vecs[3] = '{0,0,16'h0000,16'h0000, 1,0,16'h0020,16'hAAAA, 16'h0000,
                0,1,0,0,0,1,1, 16'h0000,16'h0000,16'h0020,16'hAAAA, "rd_access"};
    vecs[4] = '{0,0,16'h0000,16'h0000, 1,0,16'h0020,16'hAAAA, 16'hBEEF,
                0,0,0,1,0,1,1, 16'h0000,16'hBEEF,16'h0020,16'hAAAA, "rd_ack"};
    vecs[5] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000,
                0,0,0,0,0,0,1, 16'h0000,16'h0000,16'h0020,16'hAAAA, "rd_idle"};
    vecs[6] = '{1,1,16'h0030,16'h0BAD, 0,0,16'h0000,16'h0000, 16'h0000,
                1,0,0,0,1,1,0, 16'h0000,16'h0000,16'h0030,16'h0BAD, "drop_access"};
    vecs[7] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h1111,
                0,0,1,0,0,1,0, 16'h1111,16'h0000,16'h0030,16'h0BAD, "drop_ack"};
    vecs[8] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000,
                0,0,0,0,0,0,0, 16'h0000,16'h0000,16'h0030,16'h0BAD, "drop_idle"};

    // ---------------- reset state ----------------
    do_reset();
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_acks", {m0_ack, m1_ack}, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 1);
    check("rst_rdata", {m0_rdata, m1_rdata}, 0);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 9; i++) begin
      m0_req = vecs[i].m0_req;   m0_we = vecs[i].m0_we;
      m0_addr = vecs[i].m0_addr; m0_wdata = vecs[i].m0_wdata;
      m1_req = vecs[i].m1_req;   m1_we = vecs[i].m1_we;
      m1_addr = vecs[i].m1_addr; m1_wdata = vecs[i].m1_wdata;
      bus_rdata = vecs[i].rdata;
      tick();
      check({vecs[i].name, ".m0_gnt"},    m0_gnt,    vecs[i].e_m0_gnt);
      check({vecs[i].name, ".m1_gnt"},    m1_gnt,    vecs[i].e_m1_gnt);
      check({vecs[i].name, ".m0_ack"},    m0_ack,    vecs[i].e_m0_ack);
      check({vecs[i].name, ".m1_ack"},    m1_ack,    vecs[i].e_m1_ack);
      check({vecs[i].name, ".bus_we"},    bus_we,    vecs[i].e_bus_we);
      check({vecs[i].name, ".busy"},      busy,      vecs[i].e_busy);
      check({vecs[i].name, ".owner"},     owner,     vecs[i].e_owner);
      check({vecs[i].name, ".m0_rdata"},  m0_rdata,  vecs[i].e_m0_rdata);
      check({vecs[i].name, ".m1_rdata"},  m1_rdata,  vecs[i].e_m1_rdata);
      check({vecs[i].name, ".bus_addr"},  bus_addr,  vecs[i].e_bus_addr);
      check({vecs[i].name, ".bus_wdata"}, bus_wdata, vecs[i].e_bus_wdata);
    end

    // ---------------- simultaneous first request from reset ----------------
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 16'h0100; m0_wdata = 16'h0101;
    m1_req = 1; m1_we = 0; m1_addr = 16'h0200; m1_wdata = 16'h0000;
    tick();
    check("tie.first_m0_gnt", m0_gnt, 1);
    check("tie.first_m1_gnt", m1_gnt, 0);
    check("tie.first_addr", bus_addr, 16'h0100);
    tick();
    check("tie.m0_ack", m0_ack, 1);
    m0_req = 0;
    bus_rdata = 16'hC0DE;
    tick();
    check("tie.second_m1_gnt", m1_gnt, 1);
    check("tie.second_m0_gnt", m0_gnt, 0);
    check("tie.second_addr", bus_addr, 16'h0200);
    tick();
    check("tie.m1_ack", m1_ack, 1);
    check("tie.m1_rdata", m1_rdata, 16'hC0DE);
    m1_req = 0;
    tick();
    check("tie.idle", busy, 0);

    // ---------------- continuous contention, MAX_BURST = 2 ----------------
`ifdef ARB_FAIR_EN
    exp_order = 5'b01100;  // bit k = winner of grant k: m0, m0, m1, m1, m0
`else
    exp_order = 5'b00000;  // m0 every time, m1 starves
`endif
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 16'h0A00;
    m1_req = 1; m1_we = 0; m1_addr = 16'h0B00;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("burst[%0d].m0_gnt", k), m0_gnt, !exp_order[k]);
      check($sformatf("burst[%0d].m1_gnt", k), m1_gnt, exp_order[k]);
      tick();
      check($sformatf("burst[%0d].m0_ack", k), m0_ack, !exp_order[k]);
      check($sformatf("burst[%0d].m1_ack", k), m1_ack, exp_order[k]);
    end
    m0_req = 0; m1_req = 0;
    tick();
    check("burst.idle", busy, 0);

    // ---------------- reset pulse during a write's ACCESS cycle ----------------
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 16'h0040; m0_wdata = 16'h4444;
    tick();
    check("rstmid.access_we", bus_we, 1);
    #2 reset = 1'b1;
    #1;
    check("rstmid.bus_we", bus_we, 0);
    check("rstmid.m0_gnt", m0_gnt, 0);
    check("rstmid.busy", busy, 0);
    check("rstmid.bus_addr", bus_addr, 0);
    m0_req = 0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("rstmid.no_ack", {m0_ack, m1_ack}, 0);
    check("rstmid.idle", busy, 0);
    check("rstmid.owner", owner, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
